// File: rtl/conv_enc111_frame.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_enc111_frame                                                        |
// | Rate-1/2 K=3 (G=111,101) framed convolutional encoder with zero tail.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module conv_enc111_frame #(
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] out_pair,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_TAIL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  state_t           r_state, w_state_next;
  logic [1:0]       r_sr, w_sr_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_tail_cnt, w_tail_cnt_next;
  logic             r_out_valid, r_out_last, r_frame_done;
  logic [1:0]       r_out_pair;
  logic             w_slot_free, w_load, w_load_last, w_d;
  logic [1:0]       w_pair;

  assign w_slot_free = !r_out_valid || out_ready;
  // {g1,g0} for the bit currently being encoded (data bit or tail zero)
  assign w_pair      = {w_d ^ r_sr[1] ^ r_sr[0], w_d ^ r_sr[0]};

  always_comb begin
    w_state_next    = r_state;
    w_sr_next       = r_sr;
    w_cnt_next      = r_cnt;
    w_tail_cnt_next = r_tail_cnt;
    w_load          = 1'b0;
    w_load_last     = 1'b0;
    w_d             = 1'b0;
    in_ready        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_sr_next    = 2'b00;
          w_cnt_next   = '0;
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = w_slot_free;
        if (in_valid && w_slot_free) begin
          w_d        = in_bit;
          w_load     = 1'b1;
          w_sr_next  = {in_bit, r_sr[1]};
          w_cnt_next = r_cnt + C_CNT_ONE;
          if ((r_cnt + C_CNT_ONE) == C_LAST_CNT) begin
            w_tail_cnt_next = 1'b0;
            w_state_next    = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        if (w_slot_free) begin
          w_load          = 1'b1;
          w_sr_next       = {1'b0, r_sr[1]};
          w_tail_cnt_next = ~r_tail_cnt;
          if (r_tail_cnt) begin
            w_load_last  = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sr       <= 2'b00;
      r_cnt      <= '0;
      r_tail_cnt <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sr       <= w_sr_next;
      r_cnt      <= w_cnt_next;
      r_tail_cnt <= w_tail_cnt_next;
    end
  end

  // Output slot: a new load may replace a pair in the same cycle it transfers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_pair   <= 2'b00;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= r_out_valid && out_ready && r_out_last;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_pair  <= w_pair;
        r_out_last  <= w_load_last;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_pair   = r_out_pair;
  assign out_last   = r_out_last;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != S_IDLE) || r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_conv_enc111_frame.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_enc111_frame                                                     |
// | Directed self-checking bench for conv_enc111_frame with FRAME_LEN=4.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_conv_enc111_frame;

  localparam int          FL         = 4;
  // Hand-encoded pair streams, first pair in the top bits
  localparam logic [11:0] C_EXP_1101 = 12'b11_10_00_01_01_11;
  localparam logic [11:0] C_EXP_ZERO = 12'b00_00_00_00_00_00;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_bit, out_ready;
  logic       in_ready, out_valid, out_last, busy, frame_done;
  logic [1:0] out_pair;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  logic [1:0] rx_q[$];
  logic       last_q[$];
  int         cyc_q[$];

  conv_enc111_frame #(.FRAME_LEN(FL)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_pair   (out_pair),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every pair that will transfer at the coming edge
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        rx_q.push_back(out_pair);
        last_q.push_back(out_last);
        cyc_q.push_back(cyc);
      end
      if (frame_done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [3:0] b, input int n, input bit gap, input bit smid);
    int i = 0;
    int t = 0;
    bit ph = 1'b0;
    bit prev_gap = 1'b0;
    bit sent = 1'b0;
    bit acc;
    while (i < n && t < 100) begin
      start = smid && (i == 2) && !sent;
      if (start) sent = 1'b1;
      if (gap && ph) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_bit   = b[i];
      end
      @(negedge clk);
      if (gap && prev_gap) chk("gap_out_valid", out_valid, 0);
      acc      = in_valid && in_ready;
      prev_gap = gap && ph;
      tick();
      if (acc) i++;
      ph = ~ph;
      t++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("feed_accepted", i, n);
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while ((done_cnt < target || busy) && t < 100) begin
      tick();
      t++;
    end
    chk("done_in_time", (t < 100), 1);
  endtask

  task automatic check_frame(input string nm, input int base, input logic [11:0] exp);
    if (rx_q.size() >= base + 6) begin
      for (int k = 0; k < 6; k++) begin
        chk({nm, "_pair"}, rx_q[base+k], exp[11-2*k -: 2]);
        chk({nm, "_last"}, last_q[base+k], (k == 5));
      end
    end
  endtask

  initial begin
    int base;
    int d0;
    int t;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pair", out_pair, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // 1: back-to-back 1,0,1,1
    base = rx_q.size(); d0 = done_cnt;
    start_frame();
    feed(4'b1101, 4, 1'b0, 1'b0);
    wait_done(d0 + 1);
    chk("t1_count", rx_q.size() - base, 6);
    check_frame("t1", base, C_EXP_1101);
    if (cyc_q.size() >= base + 6) chk("t1_consecutive", cyc_q[base+5] - cyc_q[base], 5);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_busy", busy, 0);
    chk("t1_sr", dut.r_sr, 0);

    // 2: all-zero frame
    base = rx_q.size(); d0 = done_cnt;
    start_frame();
    feed(4'b0000, 4, 1'b0, 1'b0);
    wait_done(d0 + 1);
    chk("t2_count", rx_q.size() - base, 6);
    check_frame("t2", base, C_EXP_ZERO);
    chk("t2_sr", dut.r_sr, 0);

    // 3: downstream stall while the second pair is presented
    base = rx_q.size(); d0 = done_cnt;
    start_frame();
    fork
      feed(4'b1101, 4, 1'b0, 1'b0);
      begin
        t = 0;
        while (!(out_valid && rx_q.size() == base + 1) && t < 50) begin
          tick();
          t++;
        end
        chk("t3_stall_reached", (t < 50), 1);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("t3_hold_pair", out_pair, 2'b10);
          chk("t3_hold_valid", out_valid, 1);
          chk("t3_in_ready", in_ready, 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    wait_done(d0 + 1);
    chk("t3_count", rx_q.size() - base, 6);
    check_frame("t3", base, C_EXP_1101);

    // 4: input bubbles on alternate cycles, stray start in DATA
    base = rx_q.size(); d0 = done_cnt;
    start_frame();
    feed(4'b1101, 4, 1'b1, 1'b1);
    wait_done(d0 + 1);
    chk("t4_count", rx_q.size() - base, 6);
    check_frame("t4", base, C_EXP_1101);
    chk("t4_done", done_cnt - d0, 1);

    // 5: reset after two accepted bits, then a clean frame
    start_frame();
    feed(4'b1101, 2, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_pair", out_pair, 0);
    chk("t5_out_last", out_last, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_busy", busy, 0);
    chk("t5_state", dut.r_state, 0);
    rst = 1'b0;
    tick();
    base = rx_q.size(); d0 = done_cnt;
    start_frame();
    feed(4'b1101, 4, 1'b0, 1'b0);
    wait_done(d0 + 1);
    chk("t5_count", rx_q.size() - base, 6);
    check_frame("t5", base, C_EXP_1101);

    // 6: next start while the previous last pair is held
    base = rx_q.size(); d0 = done_cnt;
    start_frame();
    feed(4'b1101, 4, 1'b0, 1'b0);
    t = 0;
    while (!(out_valid && out_last) && t < 50) begin
      tick();
      t++;
    end
    chk("t6_last_seen", (t < 50), 1);
    out_ready = 1'b0;
    start_frame();
    chk("t6_hold_last", out_last, 1);
    chk("t6_hold_pair", out_pair, 2'b11);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_busy", busy, 1);
    chk("t6_state", dut.r_state, 1);
    out_ready = 1'b1;
    feed(4'b1101, 4, 1'b0, 1'b0);
    wait_done(d0 + 2);
    chk("t6_count", rx_q.size() - base, 12);
    check_frame("t6a", base, C_EXP_1101);
    check_frame("t6b", base + 6, C_EXP_1101);
    chk("t6_done", done_cnt - d0, 2);
    chk("t6_sr", dut.r_sr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_enc111_frame.md
Name: conv_enc111_frame

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder's branch-metric, ACS and traceback path.
- Accepts a frame of FRAME_LEN data bits over a valid/ready stream and emits one encoded symbol pair per bit.
- Appends 2 zero tail bits so the trellis terminates in state 00.
- Output pairs feed the channel model / decoder rx_pair input directly.

Parameters:
- FRAME_LEN, 256, data bits per frame (>=1); tail bits not included.
- CNT_W, $clog2(FRAME_LEN+1), width of the data-bit counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a frame when in IDLE
- in_valid  input  1  in_bit valid
- in_bit  input  1  data bit
- in_ready  output  1  encoder accepts in_bit this cycle
- out_valid  output  1  out_pair valid
- out_pair  output  2  encoded symbol {g1,g0}
- out_ready  input  1  downstream accepts out_pair
- out_last  output  1  marks final (2nd tail) pair of frame
- busy  output  1  frame in progress or output pending
- frame_done  output  1  one-cycle pulse when the out_last pair transfers

Behaviour:
- Encoder state sr[1:0]: sr[1] = previous bit, sr[0] = bit before that.
- For input d:
  - out_pair[1] = d^sr[1]^sr[0] (G=111)
  - out_pair[0] = d^sr[0] (G=101)
  - then sr <= {d, sr[1]}
- Reset (rst=1 at clk edge):
  - state=IDLE, sr=00, cnt=0, tail_cnt=0
  - out_valid=0, out_pair=00, out_last=0, frame_done=0
  - in_ready=0, busy=0
  - Reset mid-frame abandons the frame; no tail is emitted.
- Output slot: single register. slot_free = !out_valid || out_ready.
  - While out_valid && !out_ready, out_pair and out_last hold stable.
  - out_valid clears after a transfer unless a new pair loads in the same cycle.
- FSM states:
  - IDLE: in_ready=0. start=1 -> sr<=00, cnt<=0, go to DATA.
  - DATA: in_ready = slot_free (combinational).
    - On in_valid && in_ready: load encoded pair, out_valid<=1, out_last<=0, cnt++.
    - Latency: pair is valid the cycle after acceptance.
    - The accept that makes cnt==FRAME_LEN -> go to TAIL, tail_cnt<=0.
    - in_valid=0 cycles insert bubbles; sr is unchanged.
  - TAIL: in_ready=0. Each cycle with slot_free, encode d=0 and load it; tail_cnt++.
    - The second tail pair sets out_last=1; go to IDLE.
- frame_done=1 for exactly the cycle after out_valid && out_ready && out_last. out_last clears on that transfer.
- busy = (state!=IDLE) || out_valid.
- start outside IDLE is ignored.
- start in IDLE while the previous last pair is still held: accepted. The new frame's first bit waits for slot_free through in_ready.
- in_bit is ignored when in_valid=0 or in_ready=0.
- Trellis always ends in sr=00 after a complete frame.

Test Plan:
1. FRAME_LEN=4, start, bits 1,0,1,1 back-to-back, out_ready=1 -> out_pair sequence 11,10,00,01,01,11 on consecutive cycles; out_last only on 6th; frame_done pulses once; busy falls after it.
2. FRAME_LEN=4, all-zero bits -> six pairs 00; out_last on 6th; final sr=00.
3. Test 1 stimulus with out_ready=0 for 3 cycles after 2nd pair -> out_pair stays 10 and in_ready=0 during stall; full sequence unchanged, no bit lost or duplicated.
4. Test 1 stimulus with in_valid low on alternate cycles -> out_valid=0 in gap cycles; sequence unchanged. A start pulse in DATA has no effect.
5. rst asserted after 2 accepted bits -> next cycle all outputs zero, state IDLE. New frame with 1,0,1,1 reproduces test 1 exactly.
6. Back-to-back frames: start while the previous out_last is held by out_ready=0 -> last pair delivered first. Second frame output begins 11 for bits 1,0,1,1. frame_done pulses once per frame.
